inc_dec_counter: RTL and testbench



---
 rtl/inc_dec_counter_pkg.sv | 10 +
 rtl/inc_dec_step.sv | 28 ++
 rtl/inc_dec_counter.sv | 60 ++++++
 tb/tb_inc_dec_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/inc_dec_counter_pkg.sv
// Shared constants for the up/down counter: direction and overflow-mode encodings.
package inc_dec_counter_pkg;

    localparam logic INC  = 1'b0;
    localparam logic DEC  = 1'b1;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

endpackage

// File: rtl/inc_dec_step.sv
// Combinational add/subtract core: a +/- step as a ripple of full adders,
// step inverted and carry-in = dir on decrement (two's-complement subtract).
module inc_dec_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);
    import inc_dec_counter_pkg::*;

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b;

    assign b    = step ^ {WIDTH{dir == DEC}};
    assign c[0] = (dir == DEC);

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign r[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // On decrement the adder's carry-out is the inverse of the borrow.
    assign ovf = c[WIDTH] ^ (dir == DEC);

endmodule

// File: rtl/inc_dec_counter.sv
// Registered up/down counter with programmable step, parallel load and
// wrap/saturate overflow handling; carry pulses one cycle per over/underflow.
module inc_dec_counter
    import inc_dec_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             at_max,
    output logic             at_min
);

    logic [WIDTH-1:0] r;
    logic             ovf;
    logic [WIDTH-1:0] stepped;

    inc_dec_step #(.WIDTH(WIDTH)) u_step (
        .a    (count),
        .step (step),
        .dir  (dir),
        .r    (r),
        .ovf  (ovf)
    );

    // Clamp to the bound we ran past; wrap mode just keeps the modular result.
    always_comb begin
        stepped = r;
        if (ovf && sat == SAT)
            stepped = (dir == DEC) ? '0 : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            carry <= 1'b0;
        end else if (load) begin
            count <= load_val;
            carry <= 1'b0;
        end else if (en) begin
            count <= stepped;
            carry <= ovf;
        end else begin
            carry <= 1'b0;
        end
    end

    assign at_max = &count;
    assign at_min = ~|count;

endmodule

// File: tb/tb_inc_dec_counter.sv
// Bench for inc_dec_counter (WIDTH=4, RST_VAL=9): directed vector table,
// a hand-written saturation sequence, and random traffic vs. an integer model.
module tb_inc_dec_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, dir, sat, load;
    logic [W-1:0] step, load_val;
    logic [W-1:0] count;
    logic         carry, at_max, at_min;

    int n_chk  = 0;
    int n_pass = 0;

    inc_dec_counter #(.WIDTH(W), .RST_VAL(4'd9)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .step     (step),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, load, en, dir, sat;
        logic [3:0] lv, step;
        logic [3:0] e_cnt;
        logic       e_cy, e_max, e_min;
    } vec_t;

    task automatic drive(input logic r, input logic l, input logic [3:0] lv,
                         input logic e, input logic d, input logic s,
                         input logic [3:0] st);
        rst = r; load = l; load_val = lv; en = e; dir = d; sat = s; step = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] ec,
                       input logic ey, input logic emx, input logic emn);
        n_chk++;
        if (count === ec && carry === ey && at_max === emx && at_min === emn)
            n_pass++;
        else
            $display("FAIL %s: got count=%0d carry=%b at_max=%b at_min=%b, want count=%0d carry=%b at_max=%b at_min=%b",
                     name, count, carry, at_max, at_min, ec, ey, emx, emn);
    endtask

    vec_t tbl[$];

    // reference model state
    int   m_cnt;
    logic m_cy;

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0; sat = 1'b0;
        step = '0; load_val = '0;

        //            rst load en dir sat lv  step  cnt cy mx mn
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,  4'd0, 4'd9,  0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'd3,  4'd0, 4'd9,  0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'd14, 4'd0, 4'd14, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd3, 4'd1,  1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'd0,  4'd3, 4'd1,  0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'd13, 4'd0, 4'd13, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 4'd0,  4'd5, 4'd15, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 4'd0,  4'd5, 4'd15, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'd2,  4'd0, 4'd2,  0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0,  4'd3, 4'd15, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'd2,  4'd0, 4'd2,  0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd0,  4'd3, 4'd0,  1, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 4'd7,  4'd4, 4'd7,  0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd0, 4'd7,  0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd0,  4'd0, 4'd7,  0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd0,  4'd0, 4'd0,  0, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd0,  4'd1, 4'd0,  1, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd15,4'd15, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd1, 4'd0,  1, 0, 1});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0,  4'd1, 4'd15, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd1, 4'd0,  1, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  4'd1, 4'd1,  0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 4'd0,  4'd3, 4'd9,  0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].load, tbl[i].lv, tbl[i].en,
                  tbl[i].dir, tbl[i].sat, tbl[i].step);
            chk($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_cy,
                tbl[i].e_max, tbl[i].e_min);
        end

        // Creep into the upper bound in sat mode, sit on it, then release.
        drive(0, 1, 4'd14, 0, 0, 0, 4'd0); chk("seq_load14", 4'd14, 0, 0, 0);
        drive(0, 0, 4'd0, 1, 0, 1, 4'd1);  chk("seq_to15",   4'd15, 0, 1, 0);
        drive(0, 0, 4'd0, 1, 0, 1, 4'd1);  chk("seq_clamp1", 4'd15, 1, 1, 0);
        drive(0, 0, 4'd0, 1, 0, 1, 4'd2);  chk("seq_clamp2", 4'd15, 1, 1, 0);
        drive(0, 0, 4'd0, 0, 0, 1, 4'd2);  chk("seq_idle",   4'd15, 0, 1, 0);
        drive(0, 0, 4'd0, 1, 1, 1, 4'd6);  chk("seq_down",   4'd9,  0, 0, 0);

        // Random traffic against an integer model of the counter rules.
        m_cnt = 9;
        m_cy  = 1'b0;
        drive(1, 0, 4'd0, 0, 0, 0, 4'd0);
        chk("rand_reset", 4'd9, 0, 0, 0);
        for (int i = 0; i < 10000; i++) begin
            logic       r_rst, r_load, r_en, r_dir, r_sat;
            logic [3:0] r_lv, r_st;
            int         s;
            r_rst  = ($urandom_range(63) == 0);
            r_load = ($urandom_range(7) == 0);
            r_en   = ($urandom_range(3) != 0);
            r_dir  = 1'($urandom_range(1));
            r_sat  = 1'($urandom_range(1));
            r_lv   = 4'($urandom_range(15));
            r_st   = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
            s      = int'(r_st);

            if (r_rst) begin
                m_cnt = 9; m_cy = 1'b0;
            end else if (r_load) begin
                m_cnt = int'(r_lv); m_cy = 1'b0;
            end else if (r_en && !r_dir) begin
                if (m_cnt + s > 15) begin
                    m_cy  = 1'b1;
                    m_cnt = r_sat ? 15 : m_cnt + s - 16;
                end else begin
                    m_cy  = 1'b0;
                    m_cnt = m_cnt + s;
                end
            end else if (r_en && r_dir) begin
                if (s > m_cnt) begin
                    m_cy  = 1'b1;
                    m_cnt = r_sat ? 0 : m_cnt - s + 16;
                end else begin
                    m_cy  = 1'b0;
                    m_cnt = m_cnt - s;
                end
            end else begin
                m_cy = 1'b0;
            end

            drive(r_rst, r_load, r_lv, r_en, r_dir, r_sat, r_st);
            chk($sformatf("rand%0d", i), 4'(m_cnt), m_cy,
                m_cnt == 15, m_cnt == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
